// File: rtl/metro_gate_pkg.sv
// metro_gate_pkg: shared definitions for the metro access-gate controller.
//   gate_state_t : 3-bit controller state encoding, also exported on the debug port
//   timer_width  : width of the shared door/lockout down-counter
package metro_gate_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_GRANTED = 3'd2,
        S_DENIED  = 3'd3,
        S_LOCKOUT = 3'd4
    } gate_state_t;

    // The one timer serves both the door window and the lockout window, so it
    // must hold the larger of the two reload values; never narrower than 1 bit.
    function automatic int timer_width(input int open_cycles, input int lockout_cycles);
        int longest;
        longest = (open_cycles > lockout_cycles) ? open_cycles : lockout_cycles;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/gate_timer.sv
// gate_timer: loadable down-counter that stops at zero.
//   clk, reset_n   : clock, asynchronous active-low reset (count clears to 0)
//   i_load         : load i_load_value (takes priority over counting)
//   i_load_value   : reload value
//   i_en           : count down by one while non-zero
//   o_zero         : count is zero (decoded from the register)
module gate_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_value,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_value;
        else if (i_en && !o_zero)
            r_count <= r_count - W'(1);
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/metro_gate_ctrl.sv
// metro_gate_ctrl: access-gate controller - checks a presented code against a
// valid range, opens the door for a bounded time, locks out after repeated failures.
//   clk, reset_n          : clock, asynchronous active-low reset
//   i_validate_code       : request strobe, taken only while o_code_ready=1
//   i_access_code         : code, captured with an accepted request
//   i_passenger_through   : door sensor, ends the open window early
//   o_code_ready          : controller is idle and will accept a request
//   o_open_access_door    : door actuator drive
//   o_access_denied       : one-cycle pulse per rejected code
//   o_locked_out          : lockout window active
//   o_state_out           : current state encoding (debug)
//   o_grant_count         : saturating count of grants since reset
module metro_gate_ctrl
    import metro_gate_pkg::*;
#(
    parameter int CODE_W         = 4,
    parameter int CODE_MIN       = 4,
    parameter int CODE_MAX       = 11,
    parameter int OPEN_CYCLES    = 16,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_validate_code,
    input  logic [CODE_W-1:0] i_access_code,
    input  logic              i_passenger_through,
    output logic              o_code_ready,
    output logic              o_open_access_door,
    output logic              o_access_denied,
    output logic              o_locked_out,
    output logic [2:0]        o_state_out,
    output logic [CNT_W-1:0]  o_grant_count
);

    localparam int TW = timer_width(OPEN_CYCLES, LOCKOUT_CYCLES);
    localparam int FW = $clog2(MAX_FAILS + 1);

    gate_state_t       r_state;
    gate_state_t       w_next;
    logic [CODE_W-1:0] r_code;
    logic [FW-1:0]     r_fail_cnt;
    logic [FW-1:0]     w_fail_inc;
    logic [CNT_W-1:0]  r_grant_count;
    logic              r_code_ready;
    logic              r_open;
    logic              r_denied;
    logic              r_locked;
    logic              w_in_range;
    logic              w_grant;
    logic              w_zero;
    logic              w_load;
    logic              w_en;
    logic [TW-1:0]     w_load_value;

    assign w_in_range = (r_code >= CODE_W'(CODE_MIN)) && (r_code <= CODE_W'(CODE_MAX));
    assign w_grant    = (r_state == S_CHECK) && w_in_range;
    assign w_fail_inc = r_fail_cnt + FW'(1);

    // Both windows are loaded with N-1 on entry, so the state lasts N cycles
    // including the cycle where the timer reads zero.
    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        w_en         = 1'b0;
        w_load_value = TW'(OPEN_CYCLES - 1);
        case (r_state)
            S_IDLE:    w_next = i_validate_code ? S_CHECK : S_IDLE;
            S_CHECK: begin
                w_next = w_in_range ? S_GRANTED : S_DENIED;
                w_load = w_in_range;
            end
            S_GRANTED: begin
                w_next = (i_passenger_through || w_zero) ? S_IDLE : S_GRANTED;
                w_en   = !(i_passenger_through || w_zero);
            end
            S_DENIED: begin
                w_next       = (w_fail_inc == FW'(MAX_FAILS)) ? S_LOCKOUT : S_IDLE;
                w_load       = (w_fail_inc == FW'(MAX_FAILS));
                w_load_value = TW'(LOCKOUT_CYCLES - 1);
            end
            S_LOCKOUT: begin
                w_next = w_zero ? S_IDLE : S_LOCKOUT;
                w_en   = !w_zero;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    gate_timer #(
        .W(TW)
    ) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_load       (w_load),
        .i_load_value (w_load_value),
        .i_en         (w_en),
        .o_zero       (w_zero)
    );

    // Outputs are registered from the next state so they line up with r_state
    // and never see the inputs combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_code        <= '0;
            r_fail_cnt    <= '0;
            r_grant_count <= '0;
            r_code_ready  <= 1'b1;
            r_open        <= 1'b0;
            r_denied      <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_code_ready <= (w_next == S_IDLE);
            r_open       <= (w_next == S_GRANTED);
            r_denied     <= (w_next == S_DENIED);
            r_locked     <= (w_next == S_LOCKOUT);
            if (r_state == S_IDLE && i_validate_code)
                r_code <= i_access_code;
            if (w_grant) begin
                r_fail_cnt <= '0;
                if (r_grant_count != '1)
                    r_grant_count <= r_grant_count + CNT_W'(1);
            end else if (r_state == S_DENIED)
                r_fail_cnt <= w_fail_inc;
            else if (r_state == S_LOCKOUT && w_zero)
                r_fail_cnt <= '0;
        end
    end

    assign o_code_ready       = r_code_ready;
    assign o_open_access_door = r_open;
    assign o_access_denied    = r_denied;
    assign o_locked_out       = r_locked;
    assign o_state_out        = r_state;
    assign o_grant_count      = r_grant_count;

endmodule

// File: tb/tb_metro_gate_ctrl.sv
// tb_metro_gate_ctrl: random stimulus on two gate configurations against a
// timeline model of each accepted request.
module tb_metro_gate_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       v0, p0, v1, p1;
    logic [3:0] c0;
    logic [7:0] c1;
    logic       ready0, door0, den0, lock0;
    logic       ready1, door1, den1, lock1;
    logic [2:0] st0, st1;
    logic [15:0] gc0;
    logic [1:0] gc1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int m_acc[2];
    int m_end[2];
    int m_fails[2];
    int m_grants[2];
    bit m_ok[2];
    bit done_g = 1'b0;
    bit done_l = 1'b0;

    always #5 clk = ~clk;

    metro_gate_ctrl u_dut0 (
        .clk                 (clk),
        .reset_n             (reset_n),
        .i_validate_code     (v0),
        .i_access_code       (c0),
        .i_passenger_through (p0),
        .o_code_ready        (ready0),
        .o_open_access_door  (door0),
        .o_access_denied     (den0),
        .o_locked_out        (lock0),
        .o_state_out         (st0),
        .o_grant_count       (gc0)
    );

    metro_gate_ctrl #(
        .CODE_W      (8),
        .CODE_MIN    (100),
        .CODE_MAX    (200),
        .OPEN_CYCLES (3),
        .CNT_W       (2)
    ) u_dut1 (
        .clk                 (clk),
        .reset_n             (reset_n),
        .i_validate_code     (v1),
        .i_access_code       (c1),
        .i_passenger_through (p1),
        .o_code_ready        (ready1),
        .o_open_access_door  (door1),
        .o_access_denied     (den1),
        .o_locked_out        (lock1),
        .o_state_out         (st1),
        .o_grant_count       (gc1)
    );

    function automatic int p_min(int i);  return i ? 100 : 4;      endfunction
    function automatic int p_max(int i);  return i ? 200 : 11;     endfunction
    function automatic int p_open(int i); return i ? 3 : 16;       endfunction
    function automatic int p_gmax(int i); return i ? 3 : 65535;    endfunction

    // Expected state shown in cycle t, derived from the last accepted request:
    // check at acceptance, then either the door window or deny (+ lockout).
    function automatic int st(int i, int t);
        if (t > m_end[i]) return 0;
        if (t == m_acc[i]) return 1;
        if (m_ok[i]) return 2;
        return (t == m_acc[i] + 1) ? 3 : 4;
    endfunction

    function automatic logic [6:0] exp_out(int s);
        return {s == 0, s == 2, s == 3, s == 4, 3'(s)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_out0"}, {25'd0, ready0, door0, den0, lock0, st0}, {25'd0, exp_out(st(0, cyc))});
        check({tag, "_gc0"}, {16'd0, gc0}, m_grants[0]);
        check({tag, "_out1"}, {25'd0, ready1, door1, den1, lock1, st1}, {25'd0, exp_out(st(1, cyc))});
        check({tag, "_gc1"}, {30'd0, gc1}, m_grants[1]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_end[i]    = -1;
            m_fails[i]  = 0;
            m_grants[i] = 0;
        end
    endtask

    task automatic model_edge(input int i, input logic rst_n, input logic v, input int code, input logic p);
        int n;
        int prev;
        n    = cyc + 1;
        prev = st(i, cyc);
        if (!rst_n) begin
            m_end[i]    = -1;
            m_fails[i]  = 0;
            m_grants[i] = 0;
        end else if (prev == 0 && v) begin
            m_acc[i] = n;
            m_ok[i]  = (code >= p_min(i)) && (code <= p_max(i));
            if (m_ok[i]) begin
                m_end[i]   = n + p_open(i);
                m_fails[i] = 0;
            end else begin
                m_fails[i]++;
                if (m_fails[i] == 3) begin
                    m_end[i]   = n + 1 + 64;
                    m_fails[i] = 0;
                end else
                    m_end[i] = n + 1;
            end
        end else if (prev == 2 && p)
            m_end[i] = cyc;
        if (rst_n && st(i, n) == 2 && n == m_acc[i] + 1 && m_grants[i] < p_gmax(i))
            m_grants[i]++;
    endtask

    function automatic logic [7:0] pick_code1();
        case ($urandom_range(0, 7))
            0: return 8'd99;
            1: return 8'd100;
            2: return 8'd101;
            3: return 8'd150;
            4: return 8'd199;
            5: return 8'd200;
            6: return 8'd201;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        reset_n = 1'b0;
        {v0, p0, v1, p1} = 4'b0;
        c0 = '0;
        c1 = '0;
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = -10;
            m_ok[i]  = 1'b0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            reset_n = 1'b1;
            v0 = ($urandom_range(0, 3) == 0);
            c0 = 4'($urandom_range(0, 15));
            p0 = ($urandom_range(0, 15) == 0);
            v1 = ($urandom_range(0, 2) == 0);
            c1 = pick_code1();
            p1 = ($urandom_range(0, 15) == 0);
            if (k > 100 && ((!done_g && st(0, cyc) == 2 && cyc > m_acc[0] + 3) ||
                            (!done_l && st(0, cyc) == 4 && cyc > m_acc[0] + 10))) begin
                if (st(0, cyc) == 2) done_g = 1'b1;
                else done_l = 1'b1;
                reset_n = 1'b0;
                model_reset();
                #1;
                compare_all("async_rst");
            end
            @(posedge clk);
            model_edge(0, reset_n, v0, int'(c0), p0);
            model_edge(1, reset_n, v1, int'(c1), p1);
            cyc++;
            #1;
            compare_all("run");
        end
        check("rst_cov", {30'd0, done_g, done_l}, 32'd3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/metro_gate_ctrl.md
# metro_gate_ctrl

Parametrised access-gate controller for the metro fare line, the next generation of the single-gate access FSM. It captures a presented access code, checks it against a configurable valid range, and opens the door for a bounded time. It closes early when the passenger-through sensor fires, counts consecutive failed attempts, and enters a timed lockout after too many failures. It sits between the card/keypad front end and the door actuator, with debug state and a grant counter exported to the station monitor.

## Interface
- CODE_W, 4, access code width in bits (≥2)
- CODE_MIN, 4, lowest valid code, inclusive
- CODE_MAX, 11, highest valid code, inclusive (CODE_MIN ≤ CODE_MAX < 2**CODE_W)
- OPEN_CYCLES, 16, maximum door-open duration in cycles (≥1)
- MAX_FAILS, 3, consecutive failures that trigger lockout (≥1)
- LOCKOUT_CYCLES, 64, lockout duration in cycles (≥1)
- CNT_W, 16, grant counter width
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- validate_code  in  1  request strobe; accepted only when code_ready=1
- access_code  in  CODE_W  code, sampled in the acceptance cycle only
- passenger_through  in  1  door sensor; closes the door early
- code_ready  out  1  high in IDLE only
- open_access_door  out  1  high in GRANTED only
- access_denied  out  1  one-cycle pulse in DENIED
- locked_out  out  1  high in LOCKOUT
- state_out  out  3  current state encoding, for debug
- grant_count  out  CNT_W  total grants since reset; saturates at all-ones

## Operation
- States and encodings: IDLE=0, CHECK=1, GRANTED=2, DENIED=3, LOCKOUT=4. Any other value goes to IDLE on the next cycle.
- IDLE: when validate_code=1, capture access_code into code_q and go to CHECK. Otherwise stay in IDLE.
- CHECK: if CODE_MIN ≤ code_q ≤ CODE_MAX (unsigned), go to GRANTED. Otherwise go to DENIED.
- GRANTED:
  - On entry: load timer with OPEN_CYCLES-1, clear fail_cnt, increment grant_count (saturating).
  - Leave to IDLE when passenger_through=1, or when timer==0.
  - Otherwise decrement timer and stay.
  - If passenger_through and timer==0 occur together, go to IDLE (same result).
- DENIED: lasts exactly 1 cycle and increments fail_cnt.
  - If the new fail_cnt equals MAX_FAILS, go to LOCKOUT and load timer with LOCKOUT_CYCLES-1.
  - Otherwise go to IDLE.
- LOCKOUT: decrement timer each cycle. At timer==0, clear fail_cnt and go to IDLE.
- validate_code is ignored in every state except IDLE; there is no queueing.
- passenger_through is ignored outside GRANTED.
- fail_cnt width: $clog2(MAX_FAILS+1). Timer width: $clog2(max(OPEN_CYCLES, LOCKOUT_CYCLES)).
- All outputs are decoded from registered state or registered counters only. There is no combinational path from any input to any output.

## Timing
- Reset: state=IDLE, code_q=0, timer=0, fail_cnt=0, grant_count=0. Outputs: code_ready=1, all other outputs 0, state_out=0.
- Reset asserted in any state returns the block to IDLE immediately. The door drops asynchronously.
- Grant latency: validate_code sampled at edge N → CHECK after N → open_access_door=1 after edge N+1.
- Door stays high for exactly OPEN_CYCLES cycles unless passenger_through ends it. If passenger_through is sampled high at edge M, the door is low after edge M.
- Deny latency: access_denied is high for exactly the cycle after edge N+1.
- Lockout: locked_out is high for exactly LOCKOUT_CYCLES cycles, starting the cycle after DENIED.
- A new request is accepted on the first cycle back in IDLE. Back-to-back grants are separated by at least 1 IDLE cycle.

## Structure
- Package metro_gate_pkg holds:
  - the state encoding as a 3-bit typedef enum (gate_state_t);
  - the shared timer-width helper function.
- One sub-module, gate_timer: a loadable down-counter with load, load_value, en and zero outputs. It is shared between GRANTED and LOCKOUT. Everything else stays in metro_gate_ctrl.

## Test plan
- Default parameters, validate with code 4, then code 11, no sensor → each gives door high 16 cycles starting 2 cycles after validate; grant_count=2.
- Code 3, then code 12 → access_denied pulses 2 cycles after each validate; door stays 0; fail_cnt=2.
- Three consecutive invalid codes → locked_out high 64 cycles. A validate_code during lockout is ignored. Code 5 afterwards is granted.
- Grant with passenger_through asserted 5 cycles after the door opens → door low on the next cycle; fail_cnt cleared by the grant.
- reset_n pulsed low mid-GRANTED and mid-LOCKOUT → all outputs at reset values immediately, code_ready=1.
- CODE_W=8, CODE_MIN=100, CODE_MAX=200, OPEN_CYCLES=3, CNT_W=2 → codes 100 and 200 are granted for 3 cycles each, 99 and 201 are denied, and grant_count saturates at 3.
